// File: rtl/ssd_scan_driver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ssd_scan_driver: multiplexed seven-segment driver, frame-aligned load; the
// LEADING_ZERO_BLANK_EN macro enables leading-zero suppression.  Rev 1.0
// ----------------------------------------------------------------------------
module ssd_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int CLK_DIV     = 50000,
  parameter int DEAD_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           prescaler_q, prescaler_d;
  logic [IW-1:0]           index_q, index_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d, pend_q, pend_d;
  logic [NUM_DIGITS-1:0]   dpreg_q, dpreg_d, pend_dp_q, pend_dp_d;
  logic                    pend_full_q, pend_full_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    frame_start_q, frame_start_d;

  logic                    tick, wrap, xfer, lit_window;
  logic [NUM_DIGITS-1:0]   blank;
  logic [3:0]              cur_nib;
  logic                    cur_dp, cur_blank;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_to_seg = 7'b1000000;
      4'h1: hex_to_seg = 7'b1111001;
      4'h2: hex_to_seg = 7'b0100100;
      4'h3: hex_to_seg = 7'b0110000;
      4'h4: hex_to_seg = 7'b0011001;
      4'h5: hex_to_seg = 7'b0010010;
      4'h6: hex_to_seg = 7'b0000010;
      4'h7: hex_to_seg = 7'b1111000;
      4'h8: hex_to_seg = 7'b0000000;
      4'h9: hex_to_seg = 7'b0010000;
      4'hA: hex_to_seg = 7'b0001000;
      4'hB: hex_to_seg = 7'b0000011;
      4'hC: hex_to_seg = 7'b1000110;
      4'hD: hex_to_seg = 7'b0100001;
      4'hE: hex_to_seg = 7'b0000110;
      default: hex_to_seg = 7'b0001110;
    endcase
  endfunction

  assign tick       = (prescaler_q == PRE_LAST);
  assign wrap       = tick && (index_q == IDX_LAST);
  assign load_ready = ~rst & ~pend_full_q;
  assign xfer       = load_valid & load_ready;

  generate
    if (DEAD_CYCLES == 0) begin : g_no_dead
      assign lit_window = 1'b1;
    end else begin : g_dead
      localparam logic [PW-1:0] DEAD_P = PW'(DEAD_CYCLES);
      assign lit_window = (prescaler_q >= DEAD_P);
    end
  endgenerate

`ifdef LEADING_ZERO_BLANK_EN
  // Walk down from the top digit; a digit stays blank while everything above is a dp-less zero.
  always_comb begin : blank_comb
    logic zero_above;
    zero_above = 1'b1;
    blank      = '0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      zero_above = zero_above & (disp_q[4*k +: 4] == 4'h0) & ~dpreg_q[k];
      blank[k]   = zero_above;
    end
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    prescaler_d = tick ? '0 : prescaler_q + 1'b1;
    index_d     = index_q;
    if (tick) index_d = wrap ? '0 : index_q + 1'b1;
    disp_d      = disp_q;
    dpreg_d     = dpreg_q;
    pend_d      = pend_q;
    pend_dp_d   = pend_dp_q;
    pend_full_d = pend_full_q;
    // Display regs only move on the frame wrap, so a frame is never torn.
    if (wrap && pend_full_q) begin
      disp_d      = pend_q;
      dpreg_d     = pend_dp_q;
      pend_full_d = 1'b0;
    end
    if (xfer) begin
      pend_d      = load_data;
      pend_dp_d   = load_dp;
      pend_full_d = 1'b1;
    end
  end

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_d      = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (index_q == IW'(k)) begin
        cur_nib   = disp_q[4*k +: 4];
        cur_dp    = dpreg_q[k];
        cur_blank = blank[k];
        an_d[k]   = ~(lit_window & ~blank[k]);
      end
    end
    seg_d         = hex_to_seg(cur_nib);
    dp_d          = ~(cur_dp & lit_window & ~cur_blank);
    frame_start_d = (index_q == '0) && (prescaler_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler_q   <= '0;
      index_q       <= '0;
      disp_q        <= '0;
      dpreg_q       <= '0;
      pend_q        <= '0;
      pend_dp_q     <= '0;
      pend_full_q   <= 1'b0;
      an_q          <= '1;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      prescaler_q   <= prescaler_d;
      index_q       <= index_d;
      disp_q        <= disp_d;
      dpreg_q       <= dpreg_d;
      pend_q        <= pend_d;
      pend_dp_q     <= pend_dp_d;
      pend_full_q   <= pend_full_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: doc/ssd_scan_driver.md
Name: ssd_scan_driver

Overview:
- Parametrised time-multiplexed seven-segment driver. Successor to the fixed 4-digit display block, generalised to NUM_DIGITS digits.
- Adds a configurable scan divider, per-digit decimal points and anti-ghosting dead time.
- Adds a tear-free load handshake: new values take effect only at a frame boundary.
- Sits between the datapath, which supplies hex nibbles, and the board anode/cathode pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
CLK_DIV, 50000, clk cycles per digit slot (>=2)
DEAD_CYCLES, 0, cycles at start of each slot with all anodes off (0..CLK_DIV-1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
load_valid  in  1  new display value offered
load_ready  out  1  driver can accept a value
load_data  in  4*NUM_DIGITS  hex nibbles; digit k = load_data[4k+3:4k]; digit 0 = rightmost
load_dp  in  NUM_DIGITS  decimal point request per digit, 1 = on
an  out  NUM_DIGITS  anode enables, active-low
seg  out  7  cathodes, active-low, seg[0]=a .. seg[6]=g
dp  out  1  decimal-point cathode, active-low
frame_start  out  1  one-cycle pulse when digit 0 slot begins

Behaviour:
- Reset (rst high at posedge) sets:
  - an all 1; seg 7'h7F; dp 1; frame_start 0.
  - prescaler 0; digit index 0.
  - display regs all 0, dp regs all 0.
  - pending register empty.
  - load_ready reads 0 while rst is high and 1 from the first cycle after.
- Prescaler counts 0..CLK_DIV-1 and wraps. tick = (prescaler == CLK_DIV-1).
- On tick, index advances to index+1. It wraps from NUM_DIGITS-1 to 0. A wrap is the frame boundary.
- Handshake:
  - Transfer occurs when valid && ready at posedge.
  - On transfer, load_data/load_dp are captured into the pending register, and pending is marked full.
  - load_ready = ~pending_full.
  - On the frame-boundary tick with pending full, pending is copied to the display regs and marked empty. load_ready returns to 1 the next cycle.
  - Display regs never change mid-frame.
  - Holding load_valid while ready is low causes no capture.
- Output register: each posedge, an/seg/dp/frame_start are computed from the current index, prescaler and display regs. This gives 1-cycle latency.
  - an[index] = 0 when prescaler >= DEAD_CYCLES; otherwise all an = 1. Exactly one or zero anodes are low.
  - seg = hex decode of display nibble[index], active-low. Examples: 0 -> 7'b1000000; 1 -> 7'b1111001; 8 -> 7'b0000000; A -> 7'b0001000; F -> 7'b0001110.
  - dp = ~dp_reg[index].
  - frame_start = 1 for the cycle where index==0 && prescaler==0.
- Simultaneous boundary tick and load: the value captured that cycle goes to pending only. It is displayed from the next frame boundary.
- Reset mid-frame: everything returns to reset state immediately. A pending value is discarded.
- Widths: prescaler is $clog2(CLK_DIV) bits; index is $clog2(NUM_DIGITS) bits, minimum 1. Out-of-range index codes are never reached.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: a digit k > 0 is suppressed (anode held at 1 for its whole slot) when all of these hold:
  - its nibble and every higher nibble are 0;
  - none of those digits has dp set.
- Digit 0 is never suppressed. Suppression uses the display regs, so it is frame-stable.
- Undefined: all digits are always lit, leading zeros included.

Test Plan:
(All with NUM_DIGITS=4, CLK_DIV=4, DEAD_CYCLES=1.)
- Reset: hold rst 3 cycles -> an=4'b1111, seg=7'h7F, dp=1, load_ready=0 during rst. After release, load_ready=1 and first frame_start is seen one cycle after rst falls.
- Scan order: load 16'h1234, dp=0 -> after next boundary, each 4-cycle slot shows 1 dead cycle (an=1111), then 3 cycles of an=1110/seg=digit4 ("4"=7'b0011001). Then 1101/"3", 1011/"2", 0111/"1", repeating every 16 cycles.
- Handshake: load 16'hAAAA, then hold valid with 16'h5555 -> load_ready=0 and 5555 is not captured until after the boundary. Display switches to AAAA exactly at the next frame_start, then to 5555 one frame later.
- Boundary collision: assert valid on the wrap tick cycle -> value is not shown in the starting frame; it is shown from the following frame.
- DP: load_dp=4'b0100 -> dp=0 only while an=1011 is active (digit 2); dp=1 in dead cycles and other slots.
- LEADING_ZERO_BLANK_EN: load 16'h0070 -> digits 3 and 2 are never lit (an[3], an[2] stay 1); digits 1 ("7") and 0 ("0") are lit. Without the macro, all four are lit with "0" on the top two.
